// File: rtl/risc_sequencer_pkg.sv
// Shared definitions for the RISC control sequencer: state encoding,
// special opcodes and the bit that selects accumulator vs. store class.
package risc_sequencer_pkg;

    // Control FSM states. The encoding is fixed so a debug probe or an
    // external checker can decode the state bus directly.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_WAIT   = 3'd5,
        ST_HALTED = 3'd6,
        ST_ERROR  = 3'd7
    } seq_state_t;

    // Opcodes that the decoder handles itself instead of sending to the ALU.
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JUMP = 4'hE;

    // opcode[OP_CLASS_BIT] = 0 selects the accumulator class (0-7).
    // opcode[OP_CLASS_BIT] = 1 selects the store class (8-D).
    localparam int OP_CLASS_BIT = 3;

    // True for the states in which an instruction is in flight.
    function automatic logic is_busy_state(input seq_state_t s);
        return (s inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_WAIT});
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Watchdog for the RAM write. It clears while load is high and counts
// while count_en is high. expired is high during the TIMEOUT-th
// consecutive enabled cycle, which is the last cycle in which ram_done
// may still arrive and be treated as a success. TIMEOUT must be >= 1.
module seq_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles. The count parks at LAST so it never wraps
    // back to zero.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/risc_sequencer.sv
// Control sequencer for a small accumulator RISC.
// Flow: FETCH -> DECODE -> EXEC -> WB, then back to FETCH for accumulator
// ops. Store ops go through WAIT until the RAM reports completion.
// Every output is a flop loaded from the next-state decode, so each
// strobe is visible during the cycle spent in the state that owns it.
// No output depends combinationally on any input.
module risc_sequencer
    import risc_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [3:0]        opcode,
    input  logic              ram_done,
    output logic              fetch,
    output logic              jump,
    output logic              ldacc,
    output logic              wre,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       retired,
    output seq_state_t        state_dbg
);

    seq_state_t state;
    seq_state_t state_next;

    // Next-cycle values of the registered strobes, plus counter bumps.
    logic fetch_d;
    logic jump_d;
    logic ldacc_d;
    logic wre_d;
    logic addr_inc;
    logic ret_inc;

    // Class bit captured in DECODE so that EXEC/WB do not depend on the
    // instruction register staying stable.
    logic op_store_q;

    // A stop seen during WAIT is deferred until the write resolves.
    logic stop_pend;

    logic tmo_expired;

    seq_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (state != ST_WAIT),
        .count_en (state == ST_WAIT),
        .expired  (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode. stop outranks everything in the
    // pipeline states. In WAIT, completion outranks the timeout, and the
    // timeout outranks a pending stop.
    always_comb begin
        state_next = state;
        fetch_d    = 1'b0;
        jump_d     = 1'b0;
        ldacc_d    = 1'b0;
        wre_d      = 1'b0;
        addr_inc   = 1'b0;
        ret_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_FETCH;
                    fetch_d    = 1'b1;
                end
            end
            ST_FETCH: begin
                state_next = stop ? ST_IDLE : ST_DECODE;
            end
            ST_DECODE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (opcode == OP_HALT) begin
                    state_next = ST_HALTED;
                end else if (opcode == OP_JUMP) begin
                    state_next = ST_FETCH;
                    jump_d     = 1'b1;
                    fetch_d    = 1'b1;
                    ret_inc    = 1'b1;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WB;
                    ldacc_d    = !op_store_q;
                    wre_d      = op_store_q;
                end
            end
            ST_WB: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (!op_store_q) begin
                    state_next = ST_FETCH;
                    fetch_d    = 1'b1;
                    ret_inc    = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                    wre_d      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ram_done) begin
                    addr_inc = 1'b1;
                    ret_inc  = 1'b1;
                    if (stop_pend || stop) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_FETCH;
                        fetch_d    = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_next = ST_ERROR;
                end else begin
                    wre_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (start && !stop) begin
                    state_next = ST_FETCH;
                    fetch_d    = 1'b1;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered Moore outputs, loaded from the decode of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch  <= 1'b0;
            jump   <= 1'b0;
            ldacc  <= 1'b0;
            wre    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            error  <= 1'b0;
        end else begin
            fetch  <= fetch_d;
            jump   <= jump_d;
            ldacc  <= ldacc_d;
            wre    <= wre_d;
            busy   <= is_busy_state(state_next);
            halted <= (state_next == ST_HALTED);
            error  <= (state_next == ST_ERROR);
        end
    end

    // Write address (wraps naturally) and retired count (saturates).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            retired <= '0;
        end else begin
            if (addr_inc) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (ret_inc && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end
        end
    end

    // Capture the instruction class while the opcode is being decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_store_q <= 1'b0;
        end else if (state == ST_DECODE) begin
            op_store_q <= opcode[OP_CLASS_BIT];
        end
    end

    // Remember a stop that arrives mid-write. The flag only lives while
    // the FSM stays in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_pend <= 1'b0;
        end else if ((state == ST_WAIT) && (state_next == ST_WAIT)) begin
            stop_pend <= stop_pend || stop;
        end else begin
            stop_pend <= 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: a table of instructions plus hand-written
// sequences for halt, stop, timeout, reset and address wrap.
module tb_risc_sequencer;
    import risc_sequencer_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [3:0]        opcode;
    logic              ram_done;
    logic              fetch;
    logic              jump;
    logic              ldacc;
    logic              wre;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       retired;
    seq_state_t        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // Reference model of the architectural counters.
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_ret;

    typedef struct {
        logic [3:0] op;
        int         dly;
        bit         stop_w;
        logic       exp_ldacc;
        int         exp_wre_cyc;
    } vec_t;

    vec_t vecs[8];

    risc_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .opcode    (opcode),
        .ram_done  (ram_done),
        .fetch     (fetch),
        .jump      (jump),
        .ldacc     (ldacc),
        .wre       (wre),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .halted    (halted),
        .error     (error),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_fetch"},   32'(fetch),   0);
        check({p, "_jump"},    32'(jump),    0);
        check({p, "_ldacc"},   32'(ldacc),   0);
        check({p, "_wre"},     32'(wre),     0);
        check({p, "_busy"},    32'(busy),    0);
        check({p, "_halted"},  32'(halted),  0);
        check({p, "_error"},   32'(error),   0);
        check({p, "_wr_addr"}, 32'(wr_addr), 0);
        check({p, "_retired"}, 32'(retired), 0);
        check({p, "_state"},   32'(state_dbg), 32'(ST_IDLE));
    endtask

    // Runs one instruction. Entry: the last sample saw the DUT in FETCH.
    task automatic exec_instr(input logic [3:0] op, input int dly, input bit stop_w,
                              input logic exp_ldacc, input int exp_wre_cyc);
        int   wre_cnt;
        bit   ended;
        bit   ok;
        logic [31:0] e;
        opcode = op;
        start  = 1'b0;
        tick();
        check("decode_fetch_low", 32'(fetch), 0);
        check("decode_busy", 32'(busy), 1);
        tick();
        if (op == OP_JUMP) begin
            m_ret++;
            check("jump_strobe", 32'(jump), 1);
            check("jump_fetch", 32'(fetch), 1);
            check("jump_retired", 32'(retired), 32'(m_ret));
            return;
        end
        if (op == OP_HALT) begin
            check("halt_halted", 32'(halted), 1);
            check("halt_jump", 32'(jump), 0);
            check("halt_busy", 32'(busy), 0);
            return;
        end
        tick();
        check("wb_ldacc", 32'(ldacc), 32'(exp_ldacc));
        check("wb_wre", 32'(wre), 32'(!exp_ldacc));
        if (exp_ldacc) begin
            tick();
            m_ret++;
            check("acc_ldacc_drop", 32'(ldacc), 0);
            check("acc_fetch", 32'(fetch), 1);
            check("acc_retired", 32'(retired), 32'(m_ret));
            check("acc_wr_addr", 32'(wr_addr), 32'(m_addr));
            return;
        end
        ok = (dly >= 1) && (dly <= TIMEOUT);
        if (ok) begin
            m_addr++;
            m_ret++;
        end
        exp_q.push_back(32'(exp_wre_cyc));
        exp_q.push_back(32'(m_addr));
        exp_q.push_back(32'(m_ret));
        exp_q.push_back(ok ? 32'd0 : 32'd1);
        exp_q.push_back((ok && !stop_w) ? 32'd1 : 32'd0);
        wre_cnt = 1;
        ended   = 1'b0;
        for (int k = 1; k <= 40 && !ended; k++) begin
            tick();
            stop     = 1'b0;
            ram_done = 1'b0;
            if (!wre) begin
                ended = 1'b1;
            end else begin
                wre_cnt++;
                if (k == 1 && stop_w) stop = 1'b1;
                if (k == dly) ram_done = 1'b1;
            end
        end
        stop     = 1'b0;
        ram_done = 1'b0;
        check("wait_exit_bound", 32'(ended), 1);
        e = exp_q.pop_front(); check("store_wre_cycles", 32'(wre_cnt), e);
        e = exp_q.pop_front(); check("store_wr_addr", 32'(wr_addr), e);
        e = exp_q.pop_front(); check("store_retired", 32'(retired), e);
        e = exp_q.pop_front(); check("store_error", 32'(error), e);
        e = exp_q.pop_front(); check("store_next_fetch", 32'(fetch), e);
        check("store_next_busy", 32'(busy), e);
    endtask

    initial begin
        int d;
        vecs[0] = '{op: 4'h2, dly: 0,  stop_w: 1'b0, exp_ldacc: 1'b1, exp_wre_cyc: 0};
        vecs[1] = '{op: 4'h9, dly: 3,  stop_w: 1'b0, exp_ldacc: 1'b0, exp_wre_cyc: 4};
        vecs[2] = '{op: 4'hE, dly: 0,  stop_w: 1'b0, exp_ldacc: 1'b0, exp_wre_cyc: 0};
        vecs[3] = '{op: 4'h7, dly: 0,  stop_w: 1'b0, exp_ldacc: 1'b1, exp_wre_cyc: 0};
        vecs[4] = '{op: 4'h8, dly: 1,  stop_w: 1'b0, exp_ldacc: 1'b0, exp_wre_cyc: 2};
        vecs[5] = '{op: 4'hD, dly: 15, stop_w: 1'b0, exp_ldacc: 1'b0, exp_wre_cyc: 16};
        vecs[6] = '{op: 4'h0, dly: 0,  stop_w: 1'b0, exp_ldacc: 1'b1, exp_wre_cyc: 0};
        vecs[7] = '{op: 4'hC, dly: 2,  stop_w: 1'b0, exp_ldacc: 1'b0, exp_wre_cyc: 3};

        rst = 1'b1; start = 1'b0; stop = 1'b0; ram_done = 1'b0; opcode = 4'h0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        m_addr = '0;
        m_ret  = '0;
        tick();
        check("idle_hold_busy", 32'(busy), 0);

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        check("idle_stop_wins_busy", 32'(busy), 0);
        check("idle_stop_wins_fetch", 32'(fetch), 0);
        stop = 1'b0;
        tick();
        check("start_fetch", 32'(fetch), 1);

        for (int i = 0; i < 8; i++) begin
            exec_instr(vecs[i].op, vecs[i].dly, vecs[i].stop_w, vecs[i].exp_ldacc, vecs[i].exp_wre_cyc);
        end

        // Halt, then resume with counters preserved.
        exec_instr(OP_HALT, 0, 1'b0, 1'b0, 0);
        tick();
        check("halted_hold", 32'(halted), 1);
        start = 1'b1;
        tick();
        check("resume_fetch", 32'(fetch), 1);
        check("resume_halted_low", 32'(halted), 0);
        check("resume_retired", 32'(retired), 32'(m_ret));
        check("resume_wr_addr", 32'(wr_addr), 32'(m_addr));

        // stop during WAIT: write completes, then IDLE.
        exec_instr(4'h9, 2, 1'b1, 1'b0, 3);
        check("stop_wait_state", 32'(state_dbg), 32'(ST_IDLE));
        start = 1'b1;
        tick();
        check("after_stop_fetch", 32'(fetch), 1);

        // stop in DECODE aborts without strobes.
        opcode = 4'h2; start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_decode_busy", 32'(busy), 0);
        check("stop_decode_fetch", 32'(fetch), 0);
        check("stop_decode_ldacc", 32'(ldacc), 0);
        check("stop_decode_retired", 32'(retired), 32'(m_ret));
        start = 1'b1;
        tick();
        check("restart_fetch", 32'(fetch), 1);

        // Timeout into ERROR; start is ignored there.
        exec_instr(4'h9, 0, 1'b0, 1'b0, 16);
        check("error_state", 32'(state_dbg), 32'(ST_ERROR));
        start = 1'b1;
        tick();
        tick();
        check("error_sticky", 32'(error), 1);
        check("error_no_fetch", 32'(fetch), 0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("error_reset");
        m_addr = '0;
        m_ret  = '0;

        // Reset in the middle of WAIT.
        start = 1'b1;
        tick();
        opcode = 4'h9; start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("midwait_wre", 32'(wre), 1);
        check("midwait_state", 32'(state_dbg), 32'(ST_WAIT));
        rst = 1'b1;
        tick();
        check_all_zero("midwait_reset");
        rst = 1'b0;

        // 16 stores with random completion latency wrap the address.
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            d = $urandom_range(1, 5);
            exec_instr(4'h8 + 4'($urandom_range(0, 5)), d, 1'b0, 1'b0, d + 1);
        end
        check("wrap_addr_zero", 32'(wr_addr), 0);
        check("wrap_retired", 32'(retired), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
